// File: rtl/hdlverifier_data_jtag_wr.sv
// hdlverifier_data_jtag_wr: JTAG-to-buffer write side of the HDL Verifier data path.
// Deserialises LSB-first bits from the TAP into DATA_WIDTH words and writes each
// word to the capture/stimulus RAM at an auto-incrementing, wrapping address.
// One chunk of chunkSize words is accepted per rising edge of newChunk.
// Optional feature: define HDLV_JTAG_WR_CHECKSUM_EN to build the running word sum
// on the checksum port; otherwise checksum is tied to zero.
module hdlverifier_data_jtag_wr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_in_en,
  input  logic                  shift_in_data,
  input  logic                  newChunk,
  input  logic [ADDR_WIDTH-1:0] chunkSize,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  busy,
  output logic                  chunk_done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]      C_END = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RECV, LAST} state_t;

  state_t                state_q;
  logic                  newchunk_q;
  logic [CNT_W-1:0]      bitcnt_q;
  // Holds only the upper DATA_WIDTH-1 bits: the oldest bit is shifted out on
  // the completing strobe and never read, so it is not stored.
  logic [DATA_WIDTH-2:0] shift_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [ADDR_WIDTH-1:0] stop_q;
  logic                  wr_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  start_d;
  logic [DATA_WIDTH-1:0] word_d;
  logic                  word_end_d;

  assign start_d    = newChunk & ~newchunk_q;
  assign word_d     = {shift_in_data, shift_q};
  assign word_end_d = shift_in_en && (bitcnt_q == C_END);

  // Chunk sequencing, bit deserialisation and RAM write generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      newchunk_q <= 1'b0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      wr_data_q  <= '0;
      waddr_q    <= '0;
      stop_q     <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      newchunk_q <= newChunk;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            if (chunkSize != '0) begin
              stop_q   <= waddr_q + chunkSize - A_ONE;
              bitcnt_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= RECV;
            end else begin
              done_q   <= 1'b1;
            end
          end
        end
        RECV: begin
          // Address advances on the edge that closes the wr cycle.
          if (wr_q) waddr_q <= waddr_q + A_ONE;
          if (shift_in_en) begin
            shift_q <= word_d[DATA_WIDTH-1:1];
            if (word_end_d) begin
              wr_q      <= 1'b1;
              wr_data_q <= word_d;
              bitcnt_q  <= '0;
              if (waddr_q == stop_q) state_q <= LAST;
            end else begin
              bitcnt_q  <= bitcnt_q + C_ONE;
            end
          end
        end
        LAST: begin
          waddr_q <= waddr_q + A_ONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HDLV_JTAG_WR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;

  // Running sum of written words; cleared on an accepted start, held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if ((state_q == IDLE) && start_d) begin
      sum_q <= '0;
    end else if (wr_q) begin
      sum_q <= sum_q + wr_data_q;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

  assign wr         = wr_q;
  assign wr_data    = wr_data_q;
  assign waddr      = waddr_q;
  assign busy       = busy_q;
  assign chunk_done = done_q;

endmodule

// File: tb/tb_hdlverifier_data_jtag_wr.sv
// Self-checking bench for hdlverifier_data_jtag_wr (DATA_WIDTH=8, ADDR_WIDTH=5).
module tb_hdlverifier_data_jtag_wr;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;
`ifdef HDLV_JTAG_WR_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          shift_in_en;
  logic          shift_in_data;
  logic          newChunk;
  logic [AW-1:0] chunkSize;
  logic          wr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] waddr;
  logic          busy;
  logic          chunk_done;
  logic [DW-1:0] checksum;

  always #5 clk = ~clk;

  hdlverifier_data_jtag_wr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .shift_in_en(shift_in_en), .shift_in_data(shift_in_data),
    .newChunk(newChunk), .chunkSize(chunkSize), .wr(wr), .wr_data(wr_data),
    .waddr(waddr), .busy(busy), .chunk_done(chunk_done), .checksum(checksum)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { int size; logic [DW-1:0] w [4]; int gap; logic [DW-1:0] sum; } vec_t;

  wr_t           wq[$];
  int            done_cnt = 0;
  int            errors = 0;
  int            checks = 0;
  int            m_waddr = 0;
  logic [DW-1:0] cw [DEPTH];
  vec_t          tbl [4];

  // Observed RAM writes and chunk_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr === 1'b1) wq.push_back('{addr: waddr, data: wr_data});
    if (chunk_done === 1'b1) done_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic shift_bits(input logic [DW-1:0] w, input int nbits, input int gap);
    for (int b = 0; b < nbits; b++) begin
      shift_in_en   = 1'b1;
      shift_in_data = w[b];
      @(negedge clk);
    end
    shift_in_en   = 1'b0;
    shift_in_data = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [DW-1:0] model_sum(input int n);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < n; i++) s += cw[i];
    return CK_EN ? s : '0;
  endfunction

  // One chunk of `size` words taken from cw[]; checks every write and the end state.
  task automatic run_chunk(input string tag, input int size, input int gap, input bit mid_toggle,
                           input logic [DW-1:0] exp_sum);
    int base;
    int d0;
    base = m_waddr;
    d0   = done_cnt;
    wq.delete();
    @(negedge clk);
    newChunk  = 1'b1;
    chunkSize = AW'(size);
    @(negedge clk);
    newChunk  = 1'b0;
    chunkSize = AW'($urandom);
    check({tag, " busy_start"}, busy, (size != 0));
    for (int i = 0; i < size; i++) begin
      shift_bits(cw[i], DW, (gap < 0) ? $urandom_range(0, 2) : gap);
      if (mid_toggle && i == 0) begin
        newChunk  = 1'b1;
        chunkSize = AW'(7);
        @(negedge clk);
        newChunk  = 1'b0;
      end
    end
    for (int k = 0; k < 20 && done_cnt == d0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, " done_count"}, done_cnt - d0, 1);
    check({tag, " write_count"}, wq.size(), size);
    for (int i = 0; i < size && i < wq.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), wq[i].addr, (base + i) % DEPTH);
      check($sformatf("%s data[%0d]", tag, i), wq[i].data, cw[i]);
    end
    m_waddr = (base + size) % DEPTH;
    check({tag, " waddr_end"}, waddr, m_waddr);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " checksum"}, checksum, exp_sum);
  endtask

  initial begin
    int d0;
    reset = 1'b1; shift_in_en = 1'b0; shift_in_data = 1'b0; newChunk = 1'b0; chunkSize = '0;
    repeat (2) @(negedge clk);
    check("rst wr", wr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst waddr", waddr, 0);
    check("rst busy", busy, 0);
    check("rst chunk_done", chunk_done, 0);
    check("rst checksum", checksum, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed chunks: {size, words, inter-word gap, checksum if enabled}.
    tbl[0].size = 3; tbl[0].w = '{8'hA5, 8'h3C, 8'hFF, 8'h00}; tbl[0].gap = 2; tbl[0].sum = 8'hE0;
    tbl[1].size = 2; tbl[1].w = '{8'h80, 8'h90, 8'h00, 8'h00}; tbl[1].gap = 0; tbl[1].sum = 8'h10;
    tbl[2].size = 1; tbl[2].w = '{8'h5A, 8'h00, 8'h00, 8'h00}; tbl[2].gap = 1; tbl[2].sum = 8'h5A;
    tbl[3].size = 4; tbl[3].w = '{8'h01, 8'h02, 8'h04, 8'h08}; tbl[3].gap = 0; tbl[3].sum = 8'h0F;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 4; i++) cw[i] = tbl[t].w[i];
      run_chunk($sformatf("vec%0d", t), tbl[t].size, tbl[t].gap, 1'b0, CK_EN ? tbl[t].sum : 8'h00);
    end

    // Random chunk that brings waddr to 30, then a chunk that wraps through 0.
    for (int i = 0; i < DEPTH; i++) cw[i] = DW'($urandom);
    run_chunk("rand20", 20, -1, 1'b0, model_sum(20));
    for (int i = 0; i < DEPTH; i++) cw[i] = DW'($urandom);
    run_chunk("wrap4", 4, -1, 1'b0, model_sum(4));
    check("wrap4 waddr_lit", waddr, 2);

    // Start edge inside a chunk must be ignored.
    for (int i = 0; i < DEPTH; i++) cw[i] = DW'($urandom);
    run_chunk("midtoggle", 2, 0, 1'b1, model_sum(2));

    // Zero-size chunk with newChunk held high: exactly one chunk_done, no writes.
    d0 = done_cnt;
    wq.delete();
    newChunk  = 1'b1;
    chunkSize = '0;
    repeat (8) @(negedge clk);
    newChunk = 1'b0;
    @(negedge clk);
    check("zero done_count", done_cnt - d0, 1);
    check("zero write_count", wq.size(), 0);
    check("zero waddr", waddr, m_waddr);
    check("zero busy", busy, 0);

    // Maximum chunk size, wraps through 0 and stops exactly at its last word.
    for (int i = 0; i < DEPTH; i++) cw[i] = DW'($urandom);
    run_chunk("max31", DEPTH - 1, -1, 1'b0, model_sum(DEPTH - 1));

    // Reset after 5 bits of the second word: partial word discarded.
    for (int i = 0; i < DEPTH; i++) cw[i] = DW'($urandom);
    wq.delete();
    d0 = m_waddr;
    @(negedge clk);
    newChunk = 1'b1; chunkSize = AW'(3);
    @(negedge clk);
    newChunk = 1'b0;
    shift_bits(cw[0], DW, 0);
    shift_bits(cw[1], 5, 0);
    reset = 1'b1;
    #1;
    check("midrst wr", wr, 0);
    check("midrst wr_data", wr_data, 0);
    check("midrst waddr", waddr, 0);
    check("midrst busy", busy, 0);
    check("midrst checksum", checksum, 0);
    repeat (2) @(negedge clk);
    check("midrst wr_held", wr, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst write_count", wq.size(), 1);
    if (wq.size() > 0) begin
      check("midrst addr0", wq[0].addr, d0);
      check("midrst data0", wq[0].data, cw[0]);
    end
    m_waddr = 0;
    for (int i = 0; i < DEPTH; i++) cw[i] = DW'($urandom);
    run_chunk("postrst", 2, 1, 1'b0, model_sum(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
